inverse_filter: RTL
===================

Name: inverse_filter

Overview:
- Streaming decoder that undoes the team's two-tap sample filter, where the forward transform is y[n] = x[n] + x[n-1] mod 2^W with x[-1] = 0.
- Reconstructs x[n] = y[n] - x[n-1] recursively from the filtered stream.
- Tags each recovered sample with its even/odd phase and a running index, matching the forward block's alternating even/odd bookkeeping.
- Sits at the receive end of the filter path and uses a valid/ready handshake on both sides, so it can be back-pressured.

Parameters:
- W, 32: sample width in bits; all arithmetic is modulo 2^W.
- CNT_W, 16: width of the sample index counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous restart of decoder history, phase and index, active-high.
- in_valid  input  1  in_data holds a filtered sample y[n].
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  W  filtered sample y[n].
- out_valid  output  1  out_data holds a reconstructed sample.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  W  reconstructed sample x[n].
- out_phase  output  1  0 = even sample, 1 = odd sample.
- out_index  output  CNT_W  n modulo 2^CNT_W.

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately, including mid-stream. While reset is low and after its release:
  - out_valid=0, out_data=0, out_phase=0, out_index=0.
  - History register hist=0; internal phase and count = 0.
  - in_ready is low while reset is asserted.
- in_ready = !clear && (!out_valid || out_ready). This is a single output stage; in_ready never depends combinationally on in_valid.
- Accept condition: in_valid && in_ready. On an accept cycle, the next clock edge does all of the following:
  - out_data <= in_data - hist (W-bit wrap-around subtraction; no saturation, no carry out).
  - hist <= in_data - hist.
  - out_phase <= phase, then phase toggles.
  - out_index <= count, then count increments and wraps 2^CNT_W-1 -> 0.
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid. Throughput: 1 sample per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, out_data, out_phase and out_index stay stable and no input is accepted.
- Simultaneous pop and accept (out_valid && out_ready && in_valid): the new sample replaces the output in the same edge, with no bubble.
- Pop without accept: out_valid <= 0, and hist, phase and count are unchanged.
- clear=1 takes priority over everything except reset. At the next edge:
  - hist <= 0, phase <= 0, count <= 0.
  - out_valid <= 0; any pending output is discarded.
  - in_ready is 0 during the clear cycle, so no input is accepted.
  - The first sample accepted after clear decodes as x[0] = y[0].
- in_valid while in_ready=0 has no effect; the upstream must hold its data.

Decomposition:
- Shared package (filter_pkg), shared with the forward filter:
  - Default sample width constant (32).
  - Phase constants PHASE_EVEN=0 and PHASE_ODD=1.
- One natural sub-module: inv_stage, a combinational subtract of in_data minus hist plus the hist register with its load/clear enables.
- The top level holds the handshake, output register, phase and index counter.

Test Plan:
- Basic decode, out_ready=1: y = 5, 12, 6, 2 -> out_data = 5, 7, 0xFFFFFFFF, 3. Phases 0,1,0,1; indices 0,1,2,3; each sample appears 1 cycle after its accept.
- Back-pressure: hold out_ready=0 for 3 cycles after the first output. Required: in_ready=0 and out_data stays 5 throughout; on release, 7 follows with no loss or duplication.
- Clear mid-stream: after y = 5, 12, assert clear for 1 cycle, then send y = 9. Required: the pending output is dropped and the next output is 9 with phase 0, index 0.
- Reset mid-stream: drop reset while out_valid=1. Required: out_valid goes low immediately (asynchronously). After release, y = 4 decodes to 4 with index 0.
- Index wrap, CNT_W=2: send 6 samples. Required: indices 0,1,2,3,0,1 and phases 0,1,0,1,0,1.
- Loopback: forward filter -> inverse_filter with 1000 random samples and random in_valid/out_ready. Required: the decoded stream is bit-exact to the original input.

Source files
------------

// File: rtl/filter_pkg.sv
// Constants shared by the forward two-tap filter and its inverse decoder.
package filter_pkg;

    localparam int SAMPLE_W = 32;

    typedef enum logic {
        PHASE_EVEN = 1'b0,
        PHASE_ODD  = 1'b1
    } phase_e;

endpackage

// File: rtl/inv_stage.sv
// Recursive inverse of y[n] = x[n] + x[n-1]: x[n] = y[n] - hist, hist <= x[n] on load.
import filter_pkg::*;

module inv_stage #(
    parameter int W = SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] diff_o
);

    logic [W-1:0] hist_q, hist_d;

    always_comb begin
        diff_o = data_i - hist_q;
        hist_d = hist_q;
        if (clear_i) begin
            hist_d = '0;
        end else if (load_i) begin
            hist_d = diff_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/inverse_filter.sv
// Streaming decoder for the two-tap filter with a single registered output stage,
// tagging each recovered sample with its even/odd phase and running index.
import filter_pkg::*;

module inverse_filter #(
    parameter int W     = SAMPLE_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_phase,
    output logic [CNT_W-1:0] out_index
);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    phase_e           out_phase_q, out_phase_d;
    logic [CNT_W-1:0] out_index_q, out_index_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     diff;
    logic             accept;

    // Gated by reset so the block refuses input while held in reset.
    assign in_ready = reset && !clear && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    inv_stage #(.W(W)) u_inv_stage (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (clear),
        .load_i  (accept),
        .data_i  (in_data),
        .diff_o  (diff)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves it unassigned (no latch).
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_phase_d = out_phase_q;
        out_index_d = out_index_q;
        phase_d     = phase_q;
        count_d     = count_q;
        if (clear) begin
            out_valid_d = 1'b0;
            phase_d     = PHASE_EVEN;
            count_d     = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = diff;
            out_phase_d = phase_q;
            out_index_d = count_q;
            phase_d     = (phase_q == PHASE_EVEN) ? PHASE_ODD : PHASE_EVEN;
            count_d     = count_q + CNT_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state updates use <= so all registers see pre-edge values of each other.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_phase_q <= PHASE_EVEN;
            out_index_q <= '0;
            phase_q     <= PHASE_EVEN;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_phase_q <= out_phase_d;
            out_index_q <= out_index_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_phase = out_phase_q;
    assign out_index = out_index_q;

endmodule
